dmem_lane_ctrl: RTL and testbench

Load/store front-end for the byte-banked data memory. It sits between the CPU's memory stage and the four 8-bit RAM banks. Lane i holds bytes whose address[1:0] == i, and all banks share one row address.
- Converts RV32 byte/half/word loads and stores (including misaligned ones) into per-lane select, data and write-enable signals.
- Assembles and sign/zero-extends read data.
- Accesses that cross a word row take two cycles; the CPU is stalled during the first.

---
 rtl/dmem_lane_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_dmem_lane_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dmem_lane_ctrl.sv
// Load/store lane controller for a data memory split into four byte-wide banks.
// Lane i holds the bytes whose address[1:0] == i, and all banks share one row address.
// Byte, half and word loads and stores are turned into per-lane selects, lane data
// and a write enable. Load data is assembled from the lanes and sign- or zero-extended.
// An access that runs past the end of its row is split over two cycles. The CPU is
// stalled during the first of those cycles.
module dmem_lane_ctrl #(
    parameter int ROW_W  = 10,
    parameter int ADDR_W = ROW_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [ROW_W-1:0]  mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [31:0]       mem_d,
    input  logic [31:0]       mem_q
);

    typedef enum logic {ST_IDLE, ST_SECOND} state_t;

    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    state_t            r_state;
    logic [23:0]       r_hold;      // first-half load lanes, packed from the LSB
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic              r_we;
    logic [31:0]       r_wdata;

    logic              w_in_second;
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_size;
    logic              w_uns;
    logic              w_we;
    logic [31:0]       w_wdata;
    logic [1:0]        w_off;
    logic [ROW_W-1:0]  w_row;
    logic [2:0]        w_n;
    logic [3:0]        w_nmask;
    logic              w_cross;
    logic [2:0]        w_first_cnt;
    logic [2:0]        w_rest_cnt;
    logic [4:0]        w_lo_shift;
    logic [5:0]        w_hi_shift;
    logic [31:0]       w_q_down;
    logic [31:0]       w_wd_up;
    logic [31:0]       w_wd_down;
    logic [31:0]       w_merge;
    logic [3:0]        w_second_sel;
    logic [31:0]       w_lane_src;

    // Extend an LSB-aligned load value of the given size; word loads ignore 'uns'.
    function automatic logic [31:0] f_extend(input logic [31:0] d,
                                             input logic [1:0]  size,
                                             input logic        uns);
        logic [31:0] v;
        case (size)
            2'd0:    v = uns ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'd1:    v = uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: v = d;
        endcase
        return v;
    endfunction

    // The second half works only from the latched request. Otherwise the live request is used.
    assign w_in_second = (r_state == ST_SECOND);
    assign w_addr      = w_in_second ? r_addr     : req_addr;
    assign w_size      = w_in_second ? r_size     : req_size;
    assign w_uns       = w_in_second ? r_unsigned : req_unsigned;
    assign w_we        = w_in_second ? r_we       : req_we;
    assign w_wdata     = w_in_second ? r_wdata    : req_wdata;

    assign w_off = w_addr[1:0];
    assign w_row = w_addr[ADDR_W-1:2];

    // Decode the access size into a byte count and an unshifted lane mask.
    always_comb begin
        // NOTE: every signal in a combinational block gets a default first so no latch is inferred.
        w_n     = 3'd4;
        w_nmask = 4'b1111;
        case (w_size)
            2'd0:    begin w_n = 3'd1; w_nmask = 4'b0001; end
            2'd1:    begin w_n = 3'd2; w_nmask = 4'b0011; end
            default: begin w_n = 3'd4; w_nmask = 4'b1111; end
        endcase
    end

    assign w_cross      = ({2'b00, w_off} + {1'b0, w_n}) > 4'd4;
    assign w_first_cnt  = 3'd4 - {1'b0, w_off};          // bytes handled in the first half
    assign w_rest_cnt   = {1'b0, w_off} + w_n - 3'd4;    // bytes left for the second half
    assign w_lo_shift   = {w_off, 3'b000};
    assign w_hi_shift   = {w_first_cnt, 3'b000};
    assign w_q_down     = mem_q >> w_lo_shift;
    assign w_wd_up      = w_wdata << w_lo_shift;
    assign w_wd_down    = w_wdata >> w_hi_shift;
    assign w_merge      = {8'h00, r_hold} | (mem_q << w_hi_shift);
    assign w_second_sel = (4'b0001 << w_rest_cnt) - 4'd1;

    // Combinational outputs. Reset has the highest priority, then the second half, then the live request.
    always_comb begin
        stall      = 1'b0;
        rdata      = 32'h0;
        err        = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_sel    = 4'b0000;
        w_lane_src = 32'h0;
        if (rst) begin
            // all outputs stay idle while reset is held
        end else if (w_in_second) begin
            mem_addr   = w_row + ROW_W'(1);
            mem_sel    = w_second_sel;
            mem_we     = w_we;
            w_lane_src = w_wd_down;
            rdata      = w_we ? 32'h0 : f_extend(w_merge, w_size, w_uns);
        end else if (req_valid) begin
            mem_addr = w_row;
            if (w_size == SIZE_ILLEGAL) begin
                err = 1'b1;
            end else if (w_cross) begin
                mem_sel    = 4'b1111 << w_off;
                mem_we     = w_we;
                w_lane_src = w_wd_up;
                stall      = 1'b1;
            end else begin
                mem_sel    = w_nmask << w_off;
                mem_we     = w_we;
                w_lane_src = w_wd_up;
                rdata      = w_we ? 32'h0 : f_extend(w_q_down, w_size, w_uns);
            end
        end
    end

    // Drive store data only on the selected lanes. Unselected lanes carry zero.
    always_comb begin
        mem_d = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem_d[8*i +: 8] = mem_sel[i] ? w_lane_src[8*i +: 8] : 8'h00;
        end
    end

    // Sequencer: latch a crossing request and its first-half load lanes, then finish it in SECOND.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hold     <= 24'h0;
            r_addr     <= '0;
            r_size     <= 2'd0;
            r_unsigned <= 1'b0;
            r_we       <= 1'b0;
            r_wdata    <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && (req_size != SIZE_ILLEGAL) && w_cross) begin
                        r_state    <= ST_SECOND;
                        r_hold     <= w_q_down[23:0];
                        r_addr     <= req_addr;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_we       <= req_we;
                        r_wdata    <= req_wdata;
                    end
                end
                ST_SECOND: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Bench for dmem_lane_ctrl. A behavioural four-lane byte RAM is attached to the memory port.
// The driver applies one directed vector per cycle and queues the outputs expected for that cycle.
// A monitor pops each queued entry on the falling edge and compares it with the DUT outputs.
module tb_dmem_lane_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [11:0] req_addr = 12'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic [9:0]  mem_addr;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_d;
    logic [31:0] mem_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        bit          chk_addr;
        bit          chk_rd;
        logic [9:0]  addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] d;
        logic        stall;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic [7:0] ram [4][1024];

    always #5 clk = ~clk;

    dmem_lane_ctrl #(.ROW_W(10), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .rdata(rdata), .err(err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_sel(mem_sel), .mem_d(mem_d),
        .mem_q(mem_q)
    );

    // Banks: asynchronous read, synchronous per-lane write.
    assign mem_q = {ram[3][mem_addr], ram[2][mem_addr], ram[1][mem_addr], ram[0][mem_addr]};
    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_sel[i]) ram[i][mem_addr] <= mem_d[8*i +: 8];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input string name, input bit chk_addr, input bit chk_rd,
                                input logic [9:0] addr, input logic [3:0] sel, input logic we,
                                input logic [31:0] d, input logic stl, input logic [31:0] rd,
                                input logic er);
        exp_t e;
        e.name = name; e.chk_addr = chk_addr; e.chk_rd = chk_rd; e.addr = addr;
        e.sel = sel; e.we = we; e.d = d; e.stall = stl; e.rdata = rd; e.err = er;
        return e;
    endfunction

    // Apply one cycle of stimulus just after the rising edge and queue the expected outputs.
    task automatic step(input logic r, input logic v, input logic we, input logic [1:0] size,
                        input logic uns, input logic [11:0] addr, input logic [31:0] wd,
                        input exp_t e);
        @(posedge clk);
        #1;
        rst = r; req_valid = v; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        exp_q.push_back(e);
    endtask

    // Monitor: compare each queued expectation on the falling edge of its cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            if (mon_e.chk_addr) check({mon_e.name, " mem_addr"}, 32'(mem_addr), 32'(mon_e.addr));
            check({mon_e.name, " mem_sel"}, 32'(mem_sel), 32'(mon_e.sel));
            check({mon_e.name, " mem_we"},  32'(mem_we),  32'(mon_e.we));
            check({mon_e.name, " mem_d"},   mem_d,        mon_e.d);
            check({mon_e.name, " stall"},   32'(stall),   32'(mon_e.stall));
            check({mon_e.name, " err"},     32'(err),     32'(mon_e.err));
            if (mon_e.chk_rd) check({mon_e.name, " rdata"}, rdata, mon_e.rdata);
        end
    end

    initial begin
        for (int l = 0; l < 4; l++)
            for (int r = 0; r < 1024; r++) ram[l][r] = 8'h00;
        ram[1][1] = 8'h99; ram[3][1] = 8'h11;
        ram[0][2] = 8'h22; ram[1][2] = 8'h33; ram[2][2] = 8'h44;
        ram[1][3] = 8'hA1; ram[2][3] = 8'hB2; ram[3][3] = 8'hC3;
        ram[0][8] = 8'h04; ram[1][8] = 8'h03; ram[2][8] = 8'h02; ram[3][8] = 8'h01;

        //   rst v  we sz uns addr     wdata
        step(1, 1, 1, 2, 0, 12'h010, 32'hDEADBEEF, mk("reset",   1, 1, 10'h000, 4'b0000, 0, 32'h0, 0, 32'h0, 0));
        step(0, 1, 1, 2, 0, 12'h010, 32'hDEADBEEF, mk("sw 010",  1, 0, 10'h004, 4'b1111, 1, 32'hDEADBEEF, 0, 32'h0, 0));
        step(0, 1, 1, 2, 0, 12'h010, 32'h80123456, mk("sw 010b", 1, 0, 10'h004, 4'b1111, 1, 32'h80123456, 0, 32'h0, 0));
        step(0, 1, 0, 0, 0, 12'h013, 32'h0,        mk("lb 013",  1, 1, 10'h004, 4'b1000, 0, 32'h0, 0, 32'hFFFFFF80, 0));
        step(0, 1, 0, 0, 1, 12'h013, 32'h0,        mk("lbu 013", 1, 1, 10'h004, 4'b1000, 0, 32'h0, 0, 32'h00000080, 0));
        step(0, 1, 0, 1, 0, 12'h012, 32'h0,        mk("lh 012",  1, 1, 10'h004, 4'b1100, 0, 32'h0, 0, 32'hFFFF8012, 0));
        step(0, 1, 0, 2, 1, 12'h010, 32'h0,        mk("lwu 010", 1, 1, 10'h004, 4'b1111, 0, 32'h0, 0, 32'h80123456, 0));
        // word load crossing rows 1 -> 2
        step(0, 1, 0, 2, 0, 12'h007, 32'h0,        mk("lw 007 c1", 1, 0, 10'h001, 4'b1000, 0, 32'h0, 1, 32'h0, 0));
        step(0, 1, 0, 2, 0, 12'h007, 32'h0,        mk("lw 007 c2", 1, 1, 10'h002, 4'b0111, 0, 32'h0, 0, 32'h44332211, 0));
        // half store at the top of memory, wrapping to row 0
        step(0, 1, 1, 1, 0, 12'hFFF, 32'h0000ABCD, mk("sh FFF c1", 1, 0, 10'h3FF, 4'b1000, 1, 32'hCD000000, 1, 32'h0, 0));
        step(0, 1, 1, 1, 0, 12'hFFF, 32'h0000ABCD, mk("sh FFF c2", 1, 0, 10'h000, 4'b0001, 1, 32'h000000AB, 0, 32'h0, 0));
        step(0, 1, 0, 1, 0, 12'hFFF, 32'h0,        mk("lh FFF c1", 1, 0, 10'h3FF, 4'b1000, 0, 32'h0, 1, 32'h0, 0));
        step(0, 1, 0, 1, 0, 12'hFFF, 32'h0,        mk("lh FFF c2", 1, 1, 10'h000, 4'b0001, 0, 32'h0, 0, 32'hFFFFABCD, 0));
        // crossing store aborted by reset in its second cycle
        step(0, 1, 1, 2, 0, 12'h006, 32'h55667788, mk("sw 006 c1", 1, 0, 10'h001, 4'b1100, 1, 32'h77880000, 1, 32'h0, 0));
        step(1, 1, 1, 2, 0, 12'h006, 32'h55667788, mk("sw 006 rst",1, 1, 10'h000, 4'b0000, 0, 32'h0, 0, 32'h0, 0));
        step(0, 0, 0, 0, 0, 12'h000, 32'h0,        mk("idle",      0, 1, 10'h000, 4'b0000, 0, 32'h0, 0, 32'h0, 0));
        // illegal size, then normal service
        step(0, 1, 0, 3, 0, 12'h020, 32'h0,        mk("illegal",   0, 1, 10'h000, 4'b0000, 0, 32'h0, 0, 32'h0, 1));
        step(0, 0, 0, 0, 0, 12'h000, 32'h0,        mk("post ill",  0, 1, 10'h000, 4'b0000, 0, 32'h0, 0, 32'h0, 0));
        step(0, 1, 0, 2, 0, 12'h020, 32'h0,        mk("lw 020",    1, 1, 10'h008, 4'b1111, 0, 32'h0, 0, 32'h01020304, 0));
        step(0, 1, 1, 0, 0, 12'h021, 32'hFFFFFF5A, mk("sb 021",    1, 0, 10'h008, 4'b0010, 1, 32'h00005A00, 0, 32'h0, 0));
        step(0, 1, 0, 1, 1, 12'h005, 32'h0,        mk("lhu 005",   1, 1, 10'h001, 4'b0110, 0, 32'h0, 0, 32'h00008899, 0));
        step(0, 1, 0, 2, 0, 12'h00D, 32'h0,        mk("lw 00D c1", 1, 0, 10'h003, 4'b1110, 0, 32'h0, 1, 32'h0, 0));
        step(0, 1, 0, 2, 0, 12'h00D, 32'h0,        mk("lw 00D c2", 1, 1, 10'h004, 4'b0001, 0, 32'h0, 0, 32'h56C3B2A1, 0));
        step(0, 0, 0, 0, 0, 12'h000, 32'h0,        mk("idle end",  0, 1, 10'h000, 4'b0000, 0, 32'h0, 0, 32'h0, 0));

        // Let the monitor drain, bounded.
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
        end

        // Bank contents written by the stores above.
        check("ram r1 l2", 32'(ram[2][1]),   32'h88);
        check("ram r1 l3", 32'(ram[3][1]),   32'h77);
        check("ram r2 l0", 32'(ram[0][2]),   32'h22);
        check("ram r2 l1", 32'(ram[1][2]),   32'h33);
        check("ram 3FF l3", 32'(ram[3][1023]), 32'hCD);
        check("ram 000 l0", 32'(ram[0][0]),  32'hAB);
        check("ram r8 l1", 32'(ram[1][8]),   32'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
